// File: rtl/insertion_sort_engine.sv
// insertion_sort_engine: in-place insertion sort over a split read/write memory port; SORT_PERF_CNT_EN adds cycle_cnt/wr_cnt counters.
module insertion_sort_engine #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_WDTH:0]   arr_size,
  input  logic                 descending,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 ar_valid,
  output logic [ADDR_WDTH-1:0] ar_addr,
  input  logic                 ar_ready,
  input  logic                 r_valid,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp,
  output logic                 r_ready,
  output logic                 aw_valid,
  output logic [ADDR_WDTH-1:0] aw_addr,
  input  logic                 aw_ready,
  output logic                 w_valid,
  output logic [DATA_WDTH-1:0] w_data,
  input  logic                 w_ready,
  input  logic                 b_valid,
  input  logic [RESP_WDTH-1:0] b_resp,
  output logic                 b_ready
`ifdef SORT_PERF_CNT_EN
  ,
  output logic [31:0]          cycle_cnt,
  output logic [ADDR_WDTH*2:0] wr_cnt
`endif
);
  typedef enum logic [3:0] {
    IDLE, RD_KEY_A, RD_KEY_R, RD_CMP_A, RD_CMP_R,
    WR_SHIFT_A, WR_SHIFT_B, WR_KEY_A, WR_KEY_B, DONE, ERR
  } state_t;
  localparam logic [ADDR_WDTH:0] MAX_N = {1'b1, {ADDR_WDTH{1'b0}}};
  localparam logic [ADDR_WDTH:0] ONE = {{ADDR_WDTH{1'b0}}, 1'b1};
  state_t state;
  logic [ADDR_WDTH:0] n, i, j, n_clamp, i_nxt, i_m1, j_p1, j_m1;
  logic [DATA_WDTH-1:0] key;
  logic desc, trivial, ooo, aw_fin, w_fin, last_i, j_zero, r_fault, b_fault;
  assign n_clamp = arr_size > MAX_N ? MAX_N : arr_size;
  assign trivial = n_clamp[ADDR_WDTH:1] == '0;
  assign i_nxt = i + ONE;
  assign i_m1 = i - ONE;
  assign j_p1 = j + ONE;
  assign j_m1 = j - ONE;
  assign last_i = i_nxt == n;
  assign j_zero = j == '0;
  assign ooo = desc ? r_data < key : r_data > key;
  assign aw_fin = !aw_valid || aw_ready;
  assign w_fin = !w_valid || w_ready;
  assign r_fault = |r_resp;
  assign b_fault = |b_resp;
  // Sort sequencer: j is checked for zero before decrementing, so the scan never underflows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      ar_valid <= 1'b0;
      ar_addr <= '0;
      r_ready <= 1'b0;
      aw_valid <= 1'b0;
      aw_addr <= '0;
      w_valid <= 1'b0;
      w_data <= '0;
      b_ready <= 1'b0;
      n <= '0;
      i <= '0;
      j <= '0;
      key <= '0;
      desc <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE, ERR: if (start) begin
          done <= trivial;
          error <= 1'b0;
          n <= n_clamp;
          desc <= descending;
          i <= ONE;
          if (trivial) state <= DONE;
          else begin
            busy <= 1'b1;
            ar_valid <= 1'b1;
            ar_addr <= ONE[ADDR_WDTH-1:0];
            state <= RD_KEY_A;
          end
        end
        RD_KEY_A, RD_CMP_A: if (ar_ready) begin
          ar_valid <= 1'b0;
          r_ready <= 1'b1;
          state <= state == RD_KEY_A ? RD_KEY_R : RD_CMP_R;
        end
        RD_KEY_R: if (r_valid) begin
          r_ready <= 1'b0;
          if (r_fault) begin
            busy <= 1'b0;
            error <= 1'b1;
            state <= ERR;
          end else begin
            key <= r_data;
            j <= i_m1;
            ar_valid <= 1'b1;
            ar_addr <= i_m1[ADDR_WDTH-1:0];
            state <= RD_CMP_A;
          end
        end
        RD_CMP_R: if (r_valid) begin
          r_ready <= 1'b0;
          if (r_fault) begin
            busy <= 1'b0;
            error <= 1'b1;
            state <= ERR;
          end else if (ooo) begin
            aw_valid <= 1'b1;
            w_valid <= 1'b1;
            aw_addr <= j_p1[ADDR_WDTH-1:0];
            w_data <= r_data;
            state <= WR_SHIFT_A;
          end else if (j_p1 == i) begin
            if (last_i) begin
              busy <= 1'b0;
              done <= 1'b1;
              state <= DONE;
            end else begin
              i <= i_nxt;
              ar_valid <= 1'b1;
              ar_addr <= i_nxt[ADDR_WDTH-1:0];
              state <= RD_KEY_A;
            end
          end else begin
            aw_valid <= 1'b1;
            w_valid <= 1'b1;
            aw_addr <= j_p1[ADDR_WDTH-1:0];
            w_data <= key;
            state <= WR_KEY_A;
          end
        end
        WR_SHIFT_A, WR_KEY_A: begin
          if (aw_ready) aw_valid <= 1'b0;
          if (w_ready) w_valid <= 1'b0;
          if (aw_fin && w_fin) begin
            b_ready <= 1'b1;
            state <= state == WR_SHIFT_A ? WR_SHIFT_B : WR_KEY_B;
          end
        end
        WR_SHIFT_B: if (b_valid) begin
          b_ready <= 1'b0;
          if (b_fault) begin
            busy <= 1'b0;
            error <= 1'b1;
            state <= ERR;
          end else if (j_zero) begin
            aw_valid <= 1'b1;
            w_valid <= 1'b1;
            aw_addr <= '0;
            w_data <= key;
            state <= WR_KEY_A;
          end else begin
            j <= j_m1;
            ar_valid <= 1'b1;
            ar_addr <= j_m1[ADDR_WDTH-1:0];
            state <= RD_CMP_A;
          end
        end
        WR_KEY_B: if (b_valid) begin
          b_ready <= 1'b0;
          if (b_fault) begin
            busy <= 1'b0;
            error <= 1'b1;
            state <= ERR;
          end else if (last_i) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else begin
            i <= i_nxt;
            ar_valid <= 1'b1;
            ar_addr <= i_nxt[ADDR_WDTH-1:0];
            state <= RD_KEY_A;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SORT_PERF_CNT_EN
  logic accept;
  assign accept = start && (state == IDLE || state == DONE || state == ERR);
  // Performance counters: cleared on accepted start, frozen once the engine stops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      wr_cnt <= '0;
    end else if (accept) begin
      cycle_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (busy && !(&cycle_cnt)) cycle_cnt <= cycle_cnt + 32'd1;
      if (b_valid && b_ready && !b_fault) wr_cnt <= wr_cnt + {{(ADDR_WDTH*2){1'b0}}, 1'b1};
    end
  end
`endif
endmodule

// File: tb/tb_insertion_sort_engine.sv
// tb_insertion_sort_engine: scoreboard bench with a stalling memory model behind the read/write channels.
module tb_insertion_sort_engine;
  localparam int AW = 4, DW = 32, RW = 2, N = 16;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, descending = 1'b0;
  logic [AW:0] arr_size = '0;
  logic busy, done, error, ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic ar_ready, r_valid, aw_ready, w_ready, b_valid;
  logic [AW-1:0] ar_addr, aw_addr;
  logic [DW-1:0] r_data, w_data;
  logic [RW-1:0] r_resp, b_resp;
`ifdef SORT_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [AW*2:0] wr_cnt;
`endif

  always #5 clk = ~clk;

  insertion_sort_engine #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .arr_size(arr_size), .descending(descending),
    .busy(busy), .done(done), .error(error),
    .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
    .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_ready(aw_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready)
`ifdef SORT_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .wr_cnt(wr_cnt)
`endif
  );

  logic [DW-1:0] mem [N];
  logic [DW-1:0] init_m [N];
  logic [DW-1:0] ref_m [N];
  logic [DW-1:0] exp_q [$];
  int exp_wr_q [$];
  int checks = 0, errors = 0, viol = 0, n_ar = 0, n_aw = 0, n_wr = 0, smax = 0, load_seq = 0;
  bit fault_mode = 0;
  bit ar_hs, r_hs, aw_hs, w_hs, b_hs, ar_pend, aw_pend, w_pend;
  logic [AW-1:0] ar_hs_addr, aw_hs_addr, ar_pa, aw_pa;
  logic [DW-1:0] w_hs_data, w_pd;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake capture and protocol-stability monitor
  always @(posedge clk) begin
    ar_hs <= ar_valid && ar_ready;
    ar_hs_addr <= ar_addr;
    r_hs <= r_valid && r_ready;
    aw_hs <= aw_valid && aw_ready;
    aw_hs_addr <= aw_addr;
    w_hs <= w_valid && w_ready;
    w_hs_data <= w_data;
    b_hs <= b_valid && b_ready;
    if (ar_valid && ar_ready) n_ar <= n_ar + 1;
    if (aw_valid && aw_ready) n_aw <= n_aw + 1;
    if (!rst_n) begin
      ar_pend <= 0;
      aw_pend <= 0;
      w_pend <= 0;
    end else begin
      if ((ar_pend && (!ar_valid || ar_addr !== ar_pa)) || (aw_pend && (!aw_valid || aw_addr !== aw_pa)) ||
          (w_pend && (!w_valid || w_data !== w_pd)) || (error && (ar_valid || aw_valid || w_valid)))
        viol <= viol + 1;
      ar_pend <= ar_valid && !ar_ready;
      aw_pend <= aw_valid && !aw_ready;
      w_pend <= w_valid && !w_ready;
    end
    ar_pa <= ar_addr;
    aw_pa <= aw_addr;
    w_pd <= w_data;
  end

  initial begin : rd_slave
    int cnt;
    bit st;
    logic [AW-1:0] a;
    cnt = 0; st = 0; a = '0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ar_ready = 0; r_valid = 0; st = 0; cnt = 0;
      end else begin
        if (ar_hs) begin a = ar_hs_addr; st = 1; cnt = $urandom_range(smax, 0); end
        if (r_hs) begin st = 0; cnt = $urandom_range(smax, 0); end
        if (st) begin
          ar_ready = 0;
          if (!r_valid) begin
            if (cnt == 0) begin r_valid = 1; r_data = mem[a]; r_resp = '0; end
            else cnt--;
          end
        end else begin
          r_valid = 0;
          if (ar_valid && cnt > 0) cnt--;
          ar_ready = (cnt == 0);
        end
      end
    end
  end

  initial begin : wr_slave
    int ca, cw, cb, seen;
    bit ga, gw, st, flt, fw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    ca = 0; cw = 0; cb = 0; seen = 0; ga = 0; gw = 0; st = 0; flt = 0; fw = 0; a = '0; d = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0;
    foreach (mem[k]) mem[k] = '0;
    forever begin
      @(negedge clk);
      if (load_seq != seen) begin
        seen = load_seq;
        foreach (mem[k]) mem[k] = init_m[k];
        fw = 1;
      end
      if (!rst_n) begin
        aw_ready = 0; w_ready = 0; b_valid = 0; ga = 0; gw = 0; st = 0; ca = 0; cw = 0;
      end else begin
        if (aw_hs) begin ga = 1; a = aw_hs_addr; end
        if (w_hs) begin gw = 1; d = w_hs_data; end
        if (b_hs) begin
          b_valid = 0; st = 0; ga = 0; gw = 0;
          if (!flt) begin mem[a] = d; n_wr++; end
          ca = $urandom_range(smax, 0);
          cw = $urandom_range(smax, 0);
        end
        if (!st && ga && gw) begin
          st = 1;
          cb = $urandom_range(smax, 0);
          flt = fault_mode && fw;
          fw = 0;
        end
        if (st) begin
          aw_ready = 0; w_ready = 0;
          if (!b_valid) begin
            if (cb == 0) begin b_valid = 1; b_resp = flt ? 2'b10 : 2'b00; end
            else cb--;
          end
        end else begin
          if (!ga) begin
            if (aw_valid && ca > 0) ca--;
            aw_ready = (ca == 0);
          end else aw_ready = 0;
          if (!gw) begin
            if (w_valid && cw > 0) cw--;
            w_ready = (cw == 0);
          end else w_ready = 0;
        end
      end
    end
  end

  task automatic load(input logic [DW-1:0] a0, a1, a2, a3, input bit rnd4);
    foreach (init_m[k]) init_m[k] = $urandom_range(7, 0);
    if (!rnd4) begin
      init_m[0] = a0; init_m[1] = a1; init_m[2] = a2; init_m[3] = a3;
    end
    load_seq++;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_sort(input string nm, input int sz, input bit d, input bit exp_err);
    int n, w, j, lat, ar0, aw0, wr0;
    logic [DW-1:0] key;
    bit ok;
    n = sz > N ? N : sz;
    w = 0;
    foreach (ref_m[k]) ref_m[k] = mem[k];
    for (int i = 1; i < n; i++) begin
      key = ref_m[i];
      j = i - 1;
      while (j >= 0 && (d ? ref_m[j] < key : ref_m[j] > key)) begin
        ref_m[j + 1] = ref_m[j];
        j--;
        w++;
      end
      if (j + 1 != i) begin ref_m[j + 1] = key; w++; end
    end
    if (!exp_err) begin
      foreach (ref_m[k]) exp_q.push_back(ref_m[k]);
      exp_wr_q.push_back(w);
    end
    ar0 = n_ar; aw0 = n_aw; wr0 = n_wr;
    start = 1; arr_size = sz[AW:0]; descending = d;
    @(negedge clk);
    start = 0;
    ok = 0; lat = 0;
    for (int t = 0; t < 20000; t++) begin
      if (done || error) begin ok = 1; lat = t; break; end
      @(negedge clk);
    end
    check({nm, "_terminated"}, ok, 1);
    if (n < 2) begin
      check({nm, "_latency"}, lat, 0);
      check({nm, "_no_txn"}, (n_ar - ar0) + (n_aw - aw0), 0);
    end
    @(negedge clk);
    check({nm, "_error"}, error, exp_err);
    check({nm, "_done"}, done, !exp_err);
    check({nm, "_busy"}, busy, 0);
    if (!exp_err) begin
      foreach (mem[k]) check($sformatf("%s_mem%0d", nm, k), mem[k], exp_q.pop_front());
      w = exp_wr_q.pop_front();
      check({nm, "_writes"}, n_wr - wr0, w);
`ifdef SORT_PERF_CNT_EN
      check({nm, "_wr_cnt"}, wr_cnt, w);
`endif
    end
  endtask

  initial begin : main
    int na, nw, t;
    repeat (3) @(negedge clk);
    check("reset_outs", {busy, done, error, ar_valid, r_ready, aw_valid, w_valid, b_ready, ar_addr, aw_addr, w_data}, '0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    load(3, 1, 2, 0, 0);
    run_sort("asc4", 4, 0, 0);
    check("asc4_final", {mem[0], mem[1], mem[2], mem[3]}, {32'd0, 32'd1, 32'd2, 32'd3});

    load(3, 1, 2, 0, 0);
    run_sort("desc4", 4, 1, 0);
    check("desc4_final", {mem[0], mem[1], mem[2], mem[3]}, {32'd3, 32'd2, 32'd1, 32'd0});

    nw = n_wr;
    load(0, 1, 2, 3, 0);
    run_sort("sorted4", 4, 0, 0);
    check("sorted4_no_writes", n_wr - nw, 0);

    smax = 5;
    load(3, 1, 2, 0, 0);
    run_sort("stall4", 4, 0, 0);
    check("stall4_final", {mem[0], mem[1], mem[2], mem[3]}, {32'd0, 32'd1, 32'd2, 32'd3});
    for (int r = 0; r < 4; r++) begin
      load(0, 0, 0, 0, 1);
      run_sort($sformatf("rand%0d", r), $urandom_range(16, 2), r[0], 0);
    end
    load(0, 0, 0, 0, 1);
    run_sort("clamp", 20, 0, 0);

    smax = 0;
    load(0, 0, 0, 0, 1);
    run_sort("size0", 0, 0, 0);
    run_sort("size1", 1, 1, 0);

    fault_mode = 1;
    load(3, 1, 2, 0, 0);
    run_sort("fault", 4, 0, 1);
    na = n_ar; nw = n_aw;
    repeat (10) @(negedge clk);
    check("fault_quiet", (n_ar - na) + (n_aw - nw), 0);
    check("fault_held", error, 1);
    fault_mode = 0;
    load(3, 1, 2, 0, 0);
    run_sort("recover", 4, 0, 0);

    smax = 3;
    load(3, 1, 2, 0, 0);
    start = 1; arr_size = 5'd4; descending = 0;
    @(negedge clk);
    start = 0;
    t = 0;
    while (!aw_valid && t < 1000) begin @(negedge clk); t++; end
    check("shift_reached", aw_valid, 1);
    rst_n = 0;
    #1;
    check("async_reset_outs", {busy, done, error, ar_valid, r_ready, aw_valid, w_valid, b_ready, ar_addr, aw_addr, w_data}, '0);
    nw = n_wr; na = n_aw;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    check("reset_no_write", (n_wr - nw) + (n_aw - na), 0);
    check("reset_idle", {busy, done, error}, 0);
    load(3, 1, 2, 0, 0);
    run_sort("after_reset", 4, 1, 0);

    check("valid_stable", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
